// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_pgm.sv
// Programmable glitch-free clock divider: 50 % duty Z with separately registered ZN, TICK and ACTIVE.
// Optional graceful stop: define GF180MCU_CLKDIV_SYNC_STOP_EN to honour EN=0 only at period boundaries.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_pgm #(
   parameter int W = 4
) (
   input  logic         CLK,
   input  logic         RN,
   input  logic         EN,
   input  logic [W-1:0] DIV,
   output logic         Z,
   output logic         ZN,
   output logic         TICK,
   output logic         ACTIVE
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

`ifdef GF180MCU_CLKDIV_SYNC_STOP_EN
   localparam bit IMMEDIATE_STOP = 1'b0;
`else
   localparam bit IMMEDIATE_STOP = 1'b1;
`endif

   state_t         state_q, state_d;
   logic [W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]   div_q, div_d;
   logic           z_q, z_d;
   logic           zn_q;
   logic           tick_q, tick_d;
   logic           active_q, active_d;

   always_ff @(posedge CLK) begin
      if (!RN) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         div_q    <= '0;
         z_q      <= 1'b0;
         zn_q     <= 1'b1;
         tick_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         z_q      <= z_d;
         // ZN gets its own flop fed from the next-state of Z so both edges align.
         zn_q     <= ~z_d;
         tick_q   <= tick_d;
         active_q <= active_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      z_d      = z_q;
      tick_d   = 1'b0;
      active_d = active_q;

      unique case (state_q)
         IDLE: begin
            cnt_d    = '0;
            z_d      = 1'b0;
            active_d = 1'b0;
            if (EN) begin
               state_d  = RUN;
               div_d    = DIV;
               z_d      = 1'b1;
               tick_d   = 1'b1;
               active_d = 1'b1;
            end
         end

         RUN: begin
            if (IMMEDIATE_STOP && !EN) begin
               state_d  = IDLE;
               cnt_d    = '0;
               z_d      = 1'b0;
               active_d = 1'b0;
            end else if (cnt_q != div_q) begin
               cnt_d = cnt_q + W'(1);
            end else if (z_q) begin
               // End of the high half: fall and count the low half.
               cnt_d = '0;
               z_d   = 1'b0;
            end else begin
               // Period boundary: the only point where DIV is resampled or a stop is taken.
               cnt_d = '0;
               if (EN) begin
                  div_d  = DIV;
                  z_d    = 1'b1;
                  tick_d = 1'b1;
               end else begin
                  state_d  = IDLE;
                  active_d = 1'b0;
               end
            end
         end

         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            z_d      = 1'b0;
            active_d = 1'b0;
         end
      endcase
   end

   assign Z      = z_q;
   assign ZN     = zn_q;
   assign TICK   = tick_q;
   assign ACTIVE = active_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_pgm.sv
// Randomised and directed bench for the programmable clock divider, checked against a period-position model.
// Honours GF180MCU_CLKDIV_SYNC_STOP_EN the same way as the design.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_pgm;

   localparam int W = 4;

   logic         clk;
   logic         rn;
   logic         en;
   logic [W-1:0] div;
   logic         z, zn, tick, active;

   int checks = 0;
   int errors = 0;

   // Reference model: running flag, half-period and position within the current period.
   bit m_run = 1'b0;
   int m_h   = 1;
   int m_pos = 0;

   int cyc = 0;
   int last_tick = -1;
   int intervals[$];

`ifdef GF180MCU_CLKDIV_SYNC_STOP_EN
   localparam bit IMMEDIATE_STOP = 1'b0;
`else
   localparam bit IMMEDIATE_STOP = 1'b1;
`endif

   gf180mcu_fd_sc_mcu7t5v0__clkdiv_pgm #(.W(W)) dut (
      .CLK    (clk),
      .RN     (rn),
      .EN     (en),
      .DIV    (div),
      .Z      (z),
      .ZN     (zn),
      .TICK   (tick),
      .ACTIVE (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (!rn) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         if (en) begin
            m_run = 1'b1;
            m_h   = int'(div) + 1;
            m_pos = 0;
         end
      end else if (IMMEDIATE_STOP && !en) begin
         m_run = 1'b0;
      end else begin
         m_pos++;
         if (m_pos == 2 * m_h) begin
            if (en) begin
               m_h   = int'(div) + 1;
               m_pos = 0;
            end else begin
               m_run = 1'b0;
            end
         end
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         cyc++;
         #1;
         check("z",      int'(z),      int'(m_run && m_pos < m_h));
         check("zn",     int'(zn),     int'(!(m_run && m_pos < m_h)));
         check("tick",   int'(tick),   int'(m_run && m_pos == 0));
         check("active", int'(active), int'(m_run));
         if (tick === 1'b1) begin
            if (last_tick >= 0) intervals.push_back(cyc - last_tick);
            last_tick = cyc;
         end
      end
   endtask

   task automatic restart_tracking();
      intervals.delete();
      last_tick = -1;
   endtask

   task automatic do_reset(input int n);
      rn = 1'b0;
      step(n);
      rn = 1'b1;
   endtask

   initial begin
      rn  = 1'b0;
      en  = 1'b1;
      div = 4'd3;

      // Reset held two edges with EN high, then Z rises one cycle after release.
      step(2);
      check("rst_z", int'(z), 0);
      check("rst_zn", int'(zn), 1);
      check("rst_active", int'(active), 0);
      rn = 1'b1;
      step(1);
      check("start_z", int'(z), 1);
      check("start_tick", int'(tick), 1);
      step(10);

      // DIV=2 steady: period 6.
      do_reset(1);
      div = 4'd2;
      restart_tracking();
      step(20);
      check("div2_nint", intervals.size(), 3);
      check("div2_p0", intervals[0], 6);
      check("div2_p1", intervals[1], 6);

      // DIV=0: toggles every cycle.
      do_reset(1);
      div = 4'd0;
      restart_tracking();
      step(9);
      check("div0_nint", intervals.size(), 4);
      check("div0_p0", intervals[0], 2);

      // DIV=15: 16 high / 16 low, no wrap.
      do_reset(1);
      div = 4'd15;
      restart_tracking();
      step(70);
      check("div15_nint", intervals.size(), 2);
      check("div15_p0", intervals[0], 32);

      // DIV 2->5 during the first high cycle: 6 then 12.
      do_reset(1);
      div = 4'd2;
      restart_tracking();
      step(1);
      div = 4'd5;
      step(30);
      check("chg_nint", intervals.size(), 3);
      check("chg_p0", intervals[0], 6);
      check("chg_p1", intervals[1], 12);

      // EN dropped in the first high cycle.
      do_reset(1);
      div = 4'd2;
      en  = 1'b1;
      step(1);
      en = 1'b0;
      step(1);
      check("stop_active1", int'(active), IMMEDIATE_STOP ? 0 : 1);
      step(8);
      check("stop_active_end", int'(active), 0);

      // EN glitch low for one cycle mid-period.
      en = 1'b1;
      step(2);
      en = 1'b0;
      step(1);
      en = 1'b1;
      step(12);

      // Reset for one edge while Z high, EN held.
      div = 4'd3;
      step(5);
      while (!(z === 1'b1) && cyc < 100000) step(1);
      div = 4'd1;
      do_reset(1);
      check("midrst_z", int'(z), 0);
      step(1);
      check("midrst_restart", int'(z), 1);
      step(12);

      // Randomised traffic.
      for (int i = 0; i < 4000; i++) begin
         rn = ($urandom_range(0, 149) != 0);
         en = ($urandom_range(0, 24) != 0);
         if ($urandom_range(0, 3) == 0) div = W'($urandom_range(0, 5));
         else if ($urandom_range(0, 19) == 0) div = W'($urandom);
         step(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
